load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter MEM_WORDS, default 32, SHALL give the number of 32-bit words addressable in the attached data memory.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  CPU presents a request.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_write  input  1  1=store, 0=load.
REQ-008 req_size  input  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-009 req_signed  input  1  sign-extend sub-word loads.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  load result, right-aligned and extended.
REQ-014 resp_error  output  1  request was misaligned, illegal size, or out of range.
REQ-015 mem_read, mem_write  output  1 each  memory strobes.
REQ-016 mem_address  output  32  word-aligned address; bits [1:0] SHALL be 0.
REQ-017 mem_write_data  output  32  full word to write.
REQ-018 mem_read_data  input  32  combinational read data, valid in the same cycle that mem_read=1.

Function
REQ-019 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both 1, and all request fields SHALL be registered at acceptance.
REQ-020 FSM states SHALL be IDLE, READ, WRITE, RESP.
REQ-021 At acceptance, an error SHALL be flagged for: size 11; halfword with addr[0]=1; word with addr[1:0]!=0; or addr[31:2] >= MEM_WORDS. On error: IDLE->RESP, with no memory strobe.
REQ-022 Load: IDLE->READ (mem_read=1; capture the extracted lane)->RESP; resp_valid SHALL be asserted 2 cycles after acceptance.
REQ-023 Word store: IDLE->WRITE (mem_write=1, mem_write_data=req_wdata)->RESP; resp_valid SHALL be asserted 2 cycles after acceptance.
REQ-024 Byte/halfword store: IDLE->READ (mem_read=1, capture the old word)->WRITE (merge new lanes, preserve other bytes)->RESP; resp_valid SHALL be asserted 3 cycles after acceptance.
REQ-025 Byte lanes SHALL be little-endian: byte n lives at bits [8n+7:8n]; the halfword at addr[1]=1 lives at bits [31:16].
REQ-026 Sub-word loads SHALL be zero-extended when req_signed=0 and sign-extended when req_signed=1.
REQ-027 RESP SHALL last exactly one cycle, then return to IDLE; resp_rdata and resp_error SHALL be valid only while resp_valid=1 and 0 otherwise.
REQ-028 mem_read and mem_write SHALL never be 1 in the same cycle, and SHALL be 0 in IDLE and RESP.
REQ-029 For stores, resp_rdata SHALL be 0.
REQ-030 The CPU side SHALL be allowed back-to-back requests: a new request is accepted in the IDLE cycle following RESP.

Reset
REQ-031 With rst=1 at a rising edge: state=IDLE and all outputs 0 except req_ready=1 in the following cycle.
REQ-032 Reset mid-operation SHALL abort the operation, with no mem_write asserted after the reset edge and no resp_valid for the aborted request.

Structure
REQ-033 Shared package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-034 A combinational sub-module lsu_align SHALL perform lane extract/extend and store merge; the FSM stays in load_store_unit.

Verification
REQ-035 The bench SHALL cover a word store then load: store 0xDEADBEEF @0x10; load word @0x10 -> rdata=0xDEADBEEF, error=0, resp at +2 cycles each.
REQ-036 The bench SHALL cover a byte store merge: memory @0x20 = 0x11223344; store byte 0xAA @0x22 -> memory word = 0x11AA3344, resp at +3.
REQ-037 The bench SHALL cover sign extension: word @0x30 = 0x0000F080; load signed byte @0x30 -> 0xFFFFFF80; unsigned half @0x30 -> 0x0000F080.
REQ-038 The bench SHALL cover misaligned and out-of-range requests: load word @0x02 -> error=1, no mem strobe; load @MEM_WORDS*4 -> error=1.
REQ-039 The bench SHALL cover reset during a sub-word store: assert rst in the READ cycle -> no mem_write, no resp_valid, memory unchanged, req_ready=1 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and request legality check for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size == 2'b11 || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and byte-lane merge for stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);
  logic [4:0] sh;
  logic [31:0] lane;
  logic [31:0] mask;
  logic [31:0] rep;
  always_comb begin
    sh = {addr_lo, 3'b000};
    lane = old_word >> sh;
    ld_data = size == SZ_BYTE ? {{24{sext & lane[7]}}, lane[7:0]} :
              size == SZ_HALF ? {{16{sext & lane[15]}}, lane[15:0]} : old_word;
    mask = size == SZ_BYTE ? 32'h0000_00ff << sh :
           size == SZ_HALF ? 32'h0000_ffff << sh : 32'hffff_ffff;
    rep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    st_word = (old_word & ~mask) | (rep & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding CPU load/store engine with read-modify-write for sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  state_t state_q, state_d;
  logic write_q, write_d, sext_q, sext_d, err_q, err_d, accept, bad;
  logic [1:0] size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ld_data, st_word;
  lsu_align u_align (
    .size    (size_q),
    .sext    (sext_q),
    .addr_lo (addr_q[1:0]),
    .old_word(state_q == READ ? mem_read_data : rdata_q),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  always_comb begin
    accept = req_valid && state_q == IDLE;
    bad = misaligned(req_size, req_addr[1:0]) || {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
    state_d = state_q == IDLE  ? (!req_valid ? IDLE : bad ? RESP :
                                  (req_write && req_size == SZ_WORD) ? WRITE : READ) :
              state_q == READ  ? (write_q ? WRITE : RESP) :
              state_q == WRITE ? RESP : IDLE;
  end
  always_comb begin
    write_d = accept ? req_write : write_q;
    sext_d  = accept ? req_signed : sext_q;
    err_d   = accept ? bad : err_q;
    size_d  = accept ? req_size : size_q;
    addr_d  = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    rdata_d = state_q == READ ? (write_q ? mem_read_data : ld_data) : rdata_q;
  end
  always_comb begin
    req_ready      = state_q == IDLE;
    mem_read       = state_q == READ;
    mem_write      = state_q == WRITE;
    mem_address    = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : '0;
    mem_write_data = mem_write ? st_word : '0;
    resp_valid     = state_q == RESP;
    resp_rdata     = (resp_valid && !write_q && !err_q) ? rdata_q : '0;
    resp_error     = resp_valid && err_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench with an attached word memory model
module tb_load_store_unit;
  import lsu_pkg::*;
  localparam int MW = 32;
  logic clk, rst, req_valid, req_ready, req_write, req_signed;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic resp_valid, resp_error, mem_read, mem_write;
  logic [31:0] mem [MW];
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic wr;
    logic [1:0] sz;
    logic sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic err;
    int lat;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic err;
    int lat;
  } exp_t;
  vec_t v[21];
  exp_t sb[$];
  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );
  assign mem_read_data = mem[mem_address[6:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[6:2]] <= mem_write_data;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((mem_read && mem_write) || mem_address[1:0] != 2'b00) begin
        errors++;
        $display("FAIL strobe_rules: rd=%b wr=%b addr=%h required exclusive strobes, aligned addr", mem_read, mem_write, mem_address);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t t, input int idx);
    int lat;
    int strobes;
    logic leak;
    exp_t e;
    @(negedge clk);
    chk($sformatf("ready[%0d]", idx), {31'b0, req_ready}, 32'd1);
    req_write = t.wr;
    req_size = t.sz;
    req_signed = t.sx;
    req_addr = t.addr;
    req_wdata = t.wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    sb.push_back('{t.rdata, t.err, t.lat});
    lat = 0;
    strobes = 0;
    leak = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
      if (mem_read || mem_write) strobes++;
      if (resp_rdata != 0 || resp_error) leak = 1'b1;
    end
    e = sb.pop_front();
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout[%0d]: no resp_valid within 8 cycles, required at +%0d", idx, e.lat);
    end else begin
      chk($sformatf("rdata[%0d]", idx), resp_rdata, e.rdata);
      chk($sformatf("error[%0d]", idx), {31'b0, resp_error}, {31'b0, e.err});
      chk($sformatf("latency[%0d]", idx), lat, e.lat);
    end
    chk($sformatf("strobed[%0d]", idx), {31'b0, strobes != 0}, {31'b0, !t.err});
    chk($sformatf("idle_resp_zero[%0d]", idx), {31'b0, leak}, 32'd0);
  endtask
  initial begin
    for (int i = 0; i < MW; i++) mem[i] = '0;
    v[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2};
    v[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2};
    v[2]  = '{1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2};
    v[3]  = '{1'b1, SZ_BYTE, 1'b0, 32'h22, 32'hFFFFFFAA, 32'h0, 1'b0, 3};
    v[4]  = '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 2};
    v[5]  = '{1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0000F080, 32'h0, 1'b0, 2};
    v[6]  = '{1'b0, SZ_BYTE, 1'b1, 32'h30, 32'h0, 32'hFFFFFF80, 1'b0, 2};
    v[7]  = '{1'b0, SZ_HALF, 1'b0, 32'h30, 32'h0, 32'h0000F080, 1'b0, 2};
    v[8]  = '{1'b0, SZ_HALF, 1'b1, 32'h30, 32'h0, 32'hFFFFF080, 1'b0, 2};
    v[9]  = '{1'b0, SZ_BYTE, 1'b0, 32'h31, 32'h0, 32'h000000F0, 1'b0, 2};
    v[10] = '{1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 1};
    v[11] = '{1'b0, SZ_WORD, 1'b0, MW * 4, 32'h0, 32'h0, 1'b1, 1};
    v[12] = '{1'b0, SZ_HALF, 1'b0, 32'h31, 32'h0, 32'h0, 1'b1, 1};
    v[13] = '{1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 32'h0, 1'b1, 1};
    v[14] = '{1'b1, SZ_HALF, 1'b0, 32'h12, 32'hFFFF5566, 32'h0, 1'b0, 3};
    v[15] = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h5566BEEF, 1'b0, 2};
    v[16] = '{1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, 32'h00000011, 1'b0, 2};
    v[17] = '{1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'h000011AA, 1'b0, 2};
    v[18] = '{1'b1, SZ_BYTE, 1'b0, MW * 4, 32'h77, 32'h0, 1'b1, 1};
    v[19] = '{1'b1, SZ_WORD, 1'b0, MW * 4 - 4, 32'hCAFEF00D, 32'h0, 1'b0, 2};
    v[20] = '{1'b0, SZ_WORD, 1'b0, MW * 4 - 4, 32'h0, 32'hCAFEF00D, 1'b0, 2};
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_outs", {26'b0, resp_valid, resp_error, mem_read, mem_write, 2'b00}, 32'd0);
    chk("rst_buses", resp_rdata | mem_address | mem_write_data, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) run(v[i], i);
    chk("mem_10", mem[4], 32'h5566BEEF);
    chk("mem_20_merge", mem[8], 32'h11AA3344);
    chk("mem_30", mem[12], 32'h0000F080);
    chk("mem_7c", mem[MW - 1], 32'hCAFEF00D);
    @(negedge clk);
    req_write = 1'b1;
    req_size = SZ_BYTE;
    req_signed = 1'b0;
    req_addr = 32'h21;
    req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_read", {31'b0, mem_read}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_quiet[%0d]", i), {30'b0, mem_write, resp_valid}, 32'd0);
      @(negedge clk);
    end
    chk("abort_mem", mem[8], 32'h11AA3344);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
